// File: rtl/lift_pkg.sv
// Shared constants, slot-state type and slot-to-floor mapping for the
// two-car, five-floor hall-call dispatcher.
package lift_pkg;

   localparam logic [1:0] UP_DIRECTION   = 2'b10;
   localparam logic [1:0] DOWN_DIRECTION = 2'b01;
   localparam logic [1:0] REST           = 2'b00;

   localparam int NUM_FLOORS   = 5;
   localparam int NUM_SLOTS    = 8;
   localparam int NUM_UP_SLOTS = NUM_SLOTS / 2;
   localparam int FLOOR_W      = $clog2(NUM_FLOORS);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ASG0,
      ASG1
   } slot_state_t;

   // Slots 0-3 are up calls at floors 0-3; slots 4-7 are down calls at floors 1-4.
   function automatic logic [FLOOR_W-1:0] slot_floor(input logic [2:0] slot);
      logic [2:0] floorNum;
      floorNum = slot[2] ? (slot - 3'd3) : slot;
      return floorNum[FLOOR_W-1:0];
   endfunction

endpackage

// File: rtl/dispatch_cost.sv
// Cost of sending one car to a call floor: travel distance plus a penalty
// when the car is currently heading away from that floor.
module dispatch_cost
   import lift_pkg::*;
#(
   parameter int AWAY_PENALTY = 4
) (
   input  logic [FLOOR_W-1:0] carFloor,
   input  logic [1:0]         carDir,
   input  logic [FLOOR_W-1:0] callFloor,
   output logic [3:0]         cost
);

   logic [FLOOR_W-1:0] distance;
   logic               movingAway;

   always_comb begin
      distance   = (carFloor >= callFloor) ? (carFloor - callFloor) : (callFloor - carFloor);
      // A car at rest is never considered to be moving away.
      movingAway = ((carDir == UP_DIRECTION)   && (callFloor < carFloor)) ||
                   ((carDir == DOWN_DIRECTION) && (callFloor > carFloor));
      cost       = 4'(distance) + (movingAway ? 4'(AWAY_PENALTY) : 4'd0);
   end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher: latches calls into 8 slots, assigns one slot per
// cycle by cost, retires on car stops. DISPATCH_TIMEOUT_EN enables reassignment.
module hall_call_dispatcher
   import lift_pkg::*;
#(
   parameter int AWAY_PENALTY = 4
`ifdef DISPATCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] hall_up,
   input  logic [3:0] hall_down,
   input  logic [2:0] car0_floor,
   input  logic [1:0] car0_dir,
   input  logic       car0_stop,
   input  logic [2:0] car1_floor,
   input  logic [1:0] car1_dir,
   input  logic       car1_stop,
   output logic [3:0] car0_up_req,
   output logic [3:0] car0_down_req,
   output logic [3:0] car1_up_req,
   output logic [3:0] car1_down_req,
   output logic       assign_valid,
   output logic       assign_car,
   output logic [2:0] assign_slot
);

   genvar gi;

   logic [2:0]           scanPtr;
   logic [NUM_SLOTS-1:0] pressVec;
   logic [NUM_SLOTS-1:0] pendingVec;
   logic [NUM_SLOTS-1:0] asg0Vec;
   logic [NUM_SLOTS-1:0] asg1Vec;
   logic [FLOOR_W-1:0]   callFloor;
   logic                 assignNow;
   logic                 winnerCar;

   logic [FLOOR_W-1:0] carFloor    [2];
   logic [1:0]         carDir      [2];
   logic [3:0]         carCost     [2];
   logic [4:0]         prevPenalty [2];
   logic [4:0]         effCost     [2];

`ifdef DISPATCH_TIMEOUT_EN
   localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [NUM_SLOTS-1:0] hasPrevVec;
   logic [NUM_SLOTS-1:0] prevOwnerVec;
`endif

   assign pressVec    = {hall_down, hall_up};
   assign callFloor   = slot_floor(scanPtr);
   assign assignNow   = pendingVec[scanPtr];
   assign carFloor[0] = car0_floor;
   assign carFloor[1] = car1_floor;
   assign carDir[0]   = car0_dir;
   assign carDir[1]   = car1_dir;

   // Cost of the slot under the scan pointer, evaluated for each car.
   for (gi = 0; gi < 2; gi++) begin : gCar
      dispatch_cost #(
         .AWAY_PENALTY(AWAY_PENALTY)
      ) uCost (
         .carFloor (carFloor[gi]),
         .carDir   (carDir[gi]),
         .callFloor(callFloor),
         .cost     (carCost[gi])
      );

`ifdef DISPATCH_TIMEOUT_EN
      // A car that let this call time out is handicapped on the reassignment.
      assign prevPenalty[gi] = (hasPrevVec[scanPtr] && (prevOwnerVec[scanPtr] == 1'(gi)))
                             ? 5'(AWAY_PENALTY) : 5'd0;
`else
      assign prevPenalty[gi] = 5'd0;
`endif
      assign effCost[gi] = {1'b0, carCost[gi]} + prevPenalty[gi];
   end

   // Ties go to car 0.
   assign winnerCar = (effCost[1] < effCost[0]);

   for (gi = 0; gi < NUM_SLOTS; gi++) begin : gSlot
      localparam logic [FLOOR_W-1:0] SLOT_FLOOR = slot_floor(3'(gi));
      localparam logic [1:0]         SERVE_DIR  = (gi < NUM_UP_SLOTS) ? UP_DIRECTION : DOWN_DIRECTION;

      slot_state_t stateReg;
      logic        press;
      logic        scanHit;
      logic        owner;
      logic        retireOwn;
      logic [1:0]  retire;

      assign press   = pressVec[gi];
      assign scanHit = (scanPtr == 3'(gi));
      assign owner   = (stateReg == ASG1);

      // A stop serves this slot only if the car's direction matches the call (or the car is at rest).
      assign retire[0] = car0_stop && (car0_floor == SLOT_FLOOR) &&
                         ((car0_dir == SERVE_DIR) || (car0_dir == REST));
      assign retire[1] = car1_stop && (car1_floor == SLOT_FLOOR) &&
                         ((car1_dir == SERVE_DIR) || (car1_dir == REST));
      assign retireOwn = owner ? retire[1] : retire[0];

`ifdef DISPATCH_TIMEOUT_EN
      logic [TIMER_W-1:0] timerReg;
      logic               hasPrevReg;
      logic               prevOwnerReg;
      logic               assigned;
      logic               expired;

      assign assigned         = (stateReg == ASG0) || (stateReg == ASG1);
      assign expired          = assigned && (timerReg == TIMER_LAST);
      assign hasPrevVec[gi]   = hasPrevReg;
      assign prevOwnerVec[gi] = prevOwnerReg;
`endif

      always_ff @(posedge clk) begin
         if (reset) begin
            stateReg <= IDLE;
`ifdef DISPATCH_TIMEOUT_EN
            timerReg     <= '0;
            hasPrevReg   <= 1'b0;
            prevOwnerReg <= 1'b0;
`endif
         end else begin
            case (stateReg)
               IDLE: begin
                  if (press) stateReg <= PENDING;
               end
               PENDING: begin
                  if (scanHit) begin
                     stateReg <= winnerCar ? ASG1 : ASG0;
`ifdef DISPATCH_TIMEOUT_EN
                     hasPrevReg <= 1'b0;
`endif
                  end
               end
               ASG0, ASG1: begin
                  // A new press arriving with the retiring stop re-opens the call.
                  if (retireOwn) begin
                     stateReg <= press ? PENDING : IDLE;
`ifdef DISPATCH_TIMEOUT_EN
                     hasPrevReg <= 1'b0;
`endif
                  end
`ifdef DISPATCH_TIMEOUT_EN
                  else if (expired) begin
                     stateReg     <= PENDING;
                     hasPrevReg   <= 1'b1;
                     prevOwnerReg <= owner;
                  end
`endif
               end
               default: stateReg <= IDLE;
            endcase
`ifdef DISPATCH_TIMEOUT_EN
            timerReg <= (assigned && !retireOwn && !expired) ? (timerReg + 1'b1) : '0;
`endif
         end
      end

      assign pendingVec[gi] = (stateReg == PENDING);
      assign asg0Vec[gi]    = (stateReg == ASG0);
      assign asg1Vec[gi]    = (stateReg == ASG1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scanPtr       <= 3'd0;
         car0_up_req   <= 4'd0;
         car0_down_req <= 4'd0;
         car1_up_req   <= 4'd0;
         car1_down_req <= 4'd0;
         assign_valid  <= 1'b0;
         assign_car    <= 1'b0;
         assign_slot   <= 3'd0;
      end else begin
         scanPtr       <= scanPtr + 3'd1;
         car0_up_req   <= asg0Vec[NUM_UP_SLOTS-1:0];
         car0_down_req <= asg0Vec[NUM_SLOTS-1:NUM_UP_SLOTS];
         car1_up_req   <= asg1Vec[NUM_UP_SLOTS-1:0];
         car1_down_req <= asg1Vec[NUM_SLOTS-1:NUM_UP_SLOTS];
         assign_valid  <= assignNow;
         if (assignNow) begin
            assign_car  <= winnerCar;
            assign_slot <= scanPtr;
         end
      end
   end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Scoreboard bench for hall_call_dispatcher: expected assignments are queued
// at press time and matched by slot when assign_valid pulses.
module tb_hall_call_dispatcher;

   localparam logic [1:0] UP   = 2'b10;
   localparam logic [1:0] DOWN = 2'b01;
   localparam logic [1:0] REST = 2'b00;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] hall_up = 4'hF;
   logic [3:0] hall_down = 4'h0;
   logic [2:0] car0_floor = 3'd0;
   logic [1:0] car0_dir = REST;
   logic       car0_stop = 1'b0;
   logic [2:0] car1_floor = 3'd4;
   logic [1:0] car1_dir = REST;
   logic       car1_stop = 1'b0;
   logic [3:0] car0_up_req, car0_down_req, car1_up_req, car1_down_req;
   logic       assign_valid, assign_car;
   logic [2:0] assign_slot;

   typedef struct {
      int   slot;
      logic car;
      int   cyc;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   assignCount = 0;
   int   hitIdx;
   int   countBefore;

   hall_call_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .hall_up      (hall_up),
      .hall_down    (hall_down),
      .car0_floor   (car0_floor),
      .car0_dir     (car0_dir),
      .car0_stop    (car0_stop),
      .car1_floor   (car1_floor),
      .car1_dir     (car1_dir),
      .car1_stop    (car1_stop),
      .car0_up_req  (car0_up_req),
      .car0_down_req(car0_down_req),
      .car1_up_req  (car1_up_req),
      .car1_down_req(car1_down_req),
      .assign_valid (assign_valid),
      .assign_car   (assign_car),
      .assign_slot  (assign_slot)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cars(input logic [2:0] f0, input logic [1:0] d0,
                           input logic [2:0] f1, input logic [1:0] d1);
      car0_floor = f0;
      car0_dir   = d0;
      car1_floor = f1;
      car1_dir   = d1;
   endtask

   task automatic expect_assign(input int slot, input logic car);
      expQ.push_back('{slot: slot, car: car, cyc: cyc});
   endtask

   task automatic press_call(input bit isDown, input int bitIdx, input logic expCar);
      expect_assign(isDown ? 4 + bitIdx : bitIdx, expCar);
      if (isDown) hall_down[bitIdx] = 1'b1;
      else        hall_up[bitIdx]   = 1'b1;
      tick();
      hall_up   = 4'h0;
      hall_down = 4'h0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 14 && expQ.size() != 0; i++) tick();
      if (expQ.size() != 0) begin
         check({tag, "_assign_bound"}, 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   task automatic stop_car(input logic car);
      if (car) car1_stop = 1'b1;
      else     car0_stop = 1'b1;
      tick();
      car0_stop = 1'b0;
      car1_stop = 1'b0;
   endtask

   // Masks lag slot state by one cycle; sample two cycles after the last event.
   task automatic check_masks(input string tag, input logic [3:0] c0u, input logic [3:0] c0d,
                              input logic [3:0] c1u, input logic [3:0] c1d);
      tick();
      tick();
      check(tag, {16'd0, car0_up_req, car0_down_req, car1_up_req, car1_down_req},
                 {16'd0, c0u, c0d, c1u, c1d});
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (assign_valid === 1'b1) begin
            assignCount++;
            hitIdx = -1;
            foreach (expQ[i]) if (hitIdx < 0 && expQ[i].slot == int'(assign_slot)) hitIdx = i;
            if (hitIdx < 0) begin
               check("unexpected_assign_slot", {29'd0, assign_slot}, 32'hFF);
            end else begin
               check($sformatf("assign_car_s%0d", assign_slot), {31'd0, assign_car},
                     {31'd0, expQ[hitIdx].car});
               check($sformatf("latency_le9_s%0d", assign_slot),
                     {31'd0, (cyc - expQ[hitIdx].cyc) <= 9}, 32'd1);
               expQ.delete(hitIdx);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with presses held: everything zero, nothing latched.
      tick();
      tick();
      check("reset_outputs", {8'd0, assign_valid, assign_car, assign_slot, 1'b0,
                              car0_up_req, car0_down_req, car1_up_req, car1_down_req}, 32'd0);
      reset   = 1'b0;
      hall_up = 4'h0;
      for (int i = 0; i < 12; i++) tick();
      check("reset_no_pending", 32'(assignCount), 32'd0);
      check("reset_masks", {16'd0, car0_up_req, car0_down_req, car1_up_req, car1_down_req}, 32'd0);

      // Up call floor 1: car0 at 0 is closer than car1 at 4.
      set_cars(3'd0, REST, 3'd4, REST);
      press_call(1'b0, 1, 1'b0);
      wait_drain("up1");
      check_masks("up1_masks", 4'b0010, 4'd0, 4'd0, 4'd0);
      set_cars(3'd1, REST, 3'd4, REST);
      stop_car(1'b0);
      check_masks("up1_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Down call floor 3: cost0=3, cost1=1.
      set_cars(3'd0, REST, 3'd4, REST);
      press_call(1'b1, 2, 1'b1);
      wait_drain("dn3");
      check_masks("dn3_masks", 4'd0, 4'd0, 4'd0, 4'b0100);
      set_cars(3'd0, REST, 3'd3, DOWN);
      stop_car(1'b1);
      check_masks("dn3_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Tie at cost 1 goes to car 0.
      set_cars(3'd1, REST, 3'd3, REST);
      press_call(1'b0, 2, 1'b0);
      wait_drain("tie");
      check_masks("tie_masks", 4'b0100, 4'd0, 4'd0, 4'd0);
      set_cars(3'd2, UP, 3'd3, REST);
      stop_car(1'b0);
      check_masks("tie_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Away penalty: car0 at 2 going up, call at 1 -> cost 5 vs car1 cost 1.
      set_cars(3'd2, UP, 3'd0, REST);
      press_call(1'b0, 1, 1'b1);
      wait_drain("away");
      check_masks("away_masks", 4'd0, 4'd0, 4'b0010, 4'd0);
      set_cars(3'd2, UP, 3'd1, UP);
      stop_car(1'b1);
      check_masks("away_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Press in the same cycle as the retiring stop re-opens the call.
      press_call(1'b0, 1, 1'b1);
      wait_drain("reopen_a");
      check_masks("reopen_a_masks", 4'd0, 4'd0, 4'b0010, 4'd0);
      expect_assign(1, 1'b1);
      hall_up[1] = 1'b1;
      car1_stop  = 1'b1;
      tick();
      hall_up   = 4'h0;
      car1_stop = 1'b0;
      wait_drain("reopen_b");
      check_masks("reopen_b_masks", 4'd0, 4'd0, 4'b0010, 4'd0);
      stop_car(1'b1);
      check_masks("reopen_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Both cars stop at floor 2: each retires only its own, direction-matched slot.
      set_cars(3'd2, REST, 3'd0, REST);
      press_call(1'b0, 2, 1'b0);
      wait_drain("both_up2");
      set_cars(3'd4, REST, 3'd2, REST);
      press_call(1'b1, 1, 1'b1);
      wait_drain("both_dn2");
      check_masks("both_masks", 4'b0100, 4'd0, 4'd0, 4'b0010);
      set_cars(3'd2, UP, 3'd2, UP);
      car0_stop = 1'b1;
      car1_stop = 1'b1;
      tick();
      car0_stop = 1'b0;
      car1_stop = 1'b0;
      check_masks("both_after_stop", 4'd0, 4'd0, 4'd0, 4'b0010);
      set_cars(3'd2, UP, 3'd2, DOWN);
      stop_car(1'b1);
      check_masks("both_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Three simultaneous calls, then a wrong-direction stop that must not retire.
      set_cars(3'd0, REST, 3'd4, REST);
      expect_assign(0, 1'b0);
      expect_assign(3, 1'b1);
      expect_assign(7, 1'b1);
      hall_up   = 4'b1001;
      hall_down = 4'b1000;
      tick();
      hall_up   = 4'h0;
      hall_down = 4'h0;
      wait_drain("multi");
      check_masks("multi_masks", 4'b0001, 4'd0, 4'b1000, 4'b1000);
      set_cars(3'd0, DOWN, 3'd4, REST);
      stop_car(1'b0);
      check_masks("multi_wrong_dir", 4'b0001, 4'd0, 4'b1000, 4'b1000);
      set_cars(3'd0, REST, 3'd3, REST);
      stop_car(1'b0);
      stop_car(1'b1);
      set_cars(3'd0, REST, 3'd4, REST);
      stop_car(1'b1);
      check_masks("multi_retired", 4'd0, 4'd0, 4'd0, 4'd0);

      // Reset mid-operation drops the assignment and the presses of that cycle.
      press_call(1'b0, 0, 1'b0);
      wait_drain("midreset");
      check_masks("midreset_before", 4'b0001, 4'd0, 4'd0, 4'd0);
      reset   = 1'b1;
      hall_up = 4'hF;
      tick();
      reset   = 1'b0;
      hall_up = 4'h0;
      check("midreset_outputs", {16'd0, car0_up_req, car0_down_req, car1_up_req, car1_down_req}, 32'd0);
      countBefore = assignCount;
      for (int i = 0; i < 12; i++) tick();
      check("midreset_no_assign", 32'(assignCount - countBefore), 32'd0);
      check("midreset_masks", {16'd0, car0_up_req, car0_down_req, car1_up_req, car1_down_req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
